tcam_lookup_sched: RTL and testbench

//  Shares the single ternary match engine between two requesters: the packet-path lookup stream and CPU entry

---
 rtl/tcam_lookup_sched_if.sv | 38 +++
 rtl/tcam_lookup_sched.sv | 173 +++++++++++++++++
 tb/tb_tcam_lookup_sched.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_lookup_sched_if.sv
// Requester-side bundle for the TCAM lookup scheduler: packet lookup
// requests, lookup results and CPU entry updates.
interface tcam_lookup_sched_if #(
  parameter int unsigned KEY_W = 128,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 8
);
  logic             pkt_valid;
  logic             pkt_ready;
  logic [KEY_W-1:0] pkt_key;
  logic [TAG_W-1:0] pkt_tag;

  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic [KEY_W-1:0] upd_key;
  logic [KEY_W-1:0] upd_mask;
  logic             upd_en;

  modport master (
    output pkt_valid, pkt_key, pkt_tag, res_ready,
           upd_valid, upd_idx, upd_key, upd_mask, upd_en,
    input  pkt_ready, res_valid, res_hit, res_idx, res_tag, res_err, upd_ready
  );

  modport slave (
    input  pkt_valid, pkt_key, pkt_tag, res_ready,
           upd_valid, upd_idx, upd_key, upd_mask, upd_en,
    output pkt_ready, res_valid, res_hit, res_idx, res_tag, res_err, upd_ready
  );
endinterface

// File: rtl/tcam_lookup_sched.sv
// TCAM lookup scheduler: arbitrates the single ternary match engine between
// packet lookups and CPU entry writes, one operation at a time, holds one
// result for the action stage and keeps saturating lookup statistics.
module tcam_lookup_sched #(
  parameter int unsigned KEY_W   = 128,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              resetn,
  tcam_lookup_sched_if.slave host,
  output logic              tc_srch_start,
  output logic [KEY_W-1:0]  tc_srch_key,
  input  logic              tc_srch_done,
  input  logic              tc_hit,
  input  logic [IDX_W-1:0]  tc_idx,
  output logic              tc_wr,
  output logic [IDX_W-1:0]  tc_wr_idx,
  output logic [KEY_W-1:0]  tc_wr_key,
  output logic [KEY_W-1:0]  tc_wr_mask,
  output logic              tc_wr_en,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_hits,
  output logic [15:0]       stat_timeouts,
  input  logic              stat_clr
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0] ENTRIES_W = (IDX_W + 1)'(ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_RESP,
    S_WRITE
  } state_t;

  typedef enum logic {
    G_PKT,
    G_UPD
  } grant_t;

  state_t           state, next_state;
  grant_t           last_grant;
  logic [TMR_W-1:0] timer;
  logic [KEY_W-1:0] key_q;
  logic [TAG_W-1:0] tag_q;
  logic             wr_ok;
  logic             res_hit_q;
  logic [IDX_W-1:0] res_idx_q;
  logic             res_err_q;

  logic take_pkt;
  logic take_upd;
  logic srch_fin;
  logic srch_to;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // Arbitration, search completion detection and next-state selection
  always_comb begin
    next_state = state;
    take_pkt   = 1'b0;
    take_upd   = 1'b0;
    srch_fin   = 1'b0;
    srch_to    = 1'b0;
    case (state)
      S_IDLE: begin
        // Under contention the side not granted last time wins.
        if (host.pkt_valid && (!host.upd_valid || last_grant == G_UPD)) begin
          take_pkt   = 1'b1;
          next_state = S_SEARCH;
        end else if (host.upd_valid) begin
          take_upd   = 1'b1;
          next_state = S_WRITE;
        end
      end
      S_SEARCH: begin
        // timer==0 is the start cycle; the done strobe is only honoured after it.
        if (timer != '0 && tc_srch_done) begin
          srch_fin   = 1'b1;
          next_state = S_RESP;
        end else if (timer == TMR_W'(TIMEOUT)) begin
          srch_to    = 1'b1;
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (host.res_ready) next_state = S_IDLE;
      end
      S_WRITE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Request latching, search timer and result capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= G_PKT;
      timer      <= '0;
      key_q      <= '0;
      tag_q      <= '0;
      wr_ok      <= 1'b0;
      tc_wr_idx  <= '0;
      tc_wr_key  <= '0;
      tc_wr_mask <= '0;
      tc_wr_en   <= 1'b0;
      res_hit_q  <= 1'b0;
      res_idx_q  <= '0;
      res_err_q  <= 1'b0;
    end else begin
      if (take_pkt) begin
        last_grant <= G_PKT;
        key_q      <= host.pkt_key;
        tag_q      <= host.pkt_tag;
        timer      <= '0;
      end else if (state == S_SEARCH) begin
        timer <= timer + 1'b1;
      end
      if (take_upd) begin
        last_grant <= G_UPD;
        tc_wr_idx  <= host.upd_idx;
        tc_wr_key  <= host.upd_key;
        tc_wr_mask <= host.upd_mask;
        tc_wr_en   <= host.upd_en;
        wr_ok      <= ({1'b0, host.upd_idx} < ENTRIES_W);
      end
      if (srch_fin) begin
        res_hit_q <= tc_hit;
        res_idx_q <= tc_idx;
        res_err_q <= 1'b0;
      end else if (srch_to) begin
        res_hit_q <= 1'b0;
        res_idx_q <= '0;
        res_err_q <= 1'b1;
      end
    end
  end

  // Saturating statistics; clear takes precedence over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!resetn || stat_clr) begin
      stat_lookups  <= '0;
      stat_hits     <= '0;
      stat_timeouts <= '0;
    end else begin
      if ((srch_fin || srch_to) && stat_lookups != '1) stat_lookups <= stat_lookups + 1'b1;
      if (srch_fin && tc_hit && stat_hits != '1)       stat_hits <= stat_hits + 1'b1;
      if (srch_to && stat_timeouts != '1)               stat_timeouts <= stat_timeouts + 1'b1;
    end
  end

  assign host.pkt_ready = take_pkt;
  assign host.upd_ready = (state == S_WRITE);
  assign host.res_valid = (state == S_RESP);
  assign host.res_hit   = res_hit_q;
  assign host.res_idx   = res_idx_q;
  assign host.res_tag   = tag_q;
  assign host.res_err   = res_err_q;

  assign tc_srch_start  = (state == S_SEARCH) && (timer == '0);
  assign tc_srch_key    = key_q;
  assign tc_wr          = (state == S_WRITE) && wr_ok;

endmodule

// File: tb/tb_tcam_lookup_sched.sv
// Directed bench for tcam_lookup_sched (ENTRIES=12, TIMEOUT=15).
module tb_tcam_lookup_sched;
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned ENTRIES = 12;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned IDX_W   = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tcam_lookup_sched_if #(.KEY_W(KEY_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) host_bus ();

  logic             tc_srch_start;
  logic [KEY_W-1:0] tc_srch_key;
  logic             tc_srch_done;
  logic             tc_hit;
  logic [IDX_W-1:0] tc_idx;
  logic             tc_wr;
  logic [IDX_W-1:0] tc_wr_idx;
  logic [KEY_W-1:0] tc_wr_key;
  logic [KEY_W-1:0] tc_wr_mask;
  logic             tc_wr_en;
  logic [31:0]      stat_lookups;
  logic [31:0]      stat_hits;
  logic [15:0]      stat_timeouts;
  logic             stat_clr;

  int total = 0;
  int bad   = 0;

  tcam_lookup_sched #(
    .KEY_W(KEY_W), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .host(host_bus),
    .tc_srch_start(tc_srch_start), .tc_srch_key(tc_srch_key),
    .tc_srch_done(tc_srch_done), .tc_hit(tc_hit), .tc_idx(tc_idx),
    .tc_wr(tc_wr), .tc_wr_idx(tc_wr_idx), .tc_wr_key(tc_wr_key),
    .tc_wr_mask(tc_wr_mask), .tc_wr_en(tc_wr_en),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits),
    .stat_timeouts(stat_timeouts), .stat_clr(stat_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_bus.pkt_valid = 1'b0;
    host_bus.pkt_key   = '0;
    host_bus.pkt_tag   = '0;
    host_bus.res_ready = 1'b0;
    host_bus.upd_valid = 1'b0;
    host_bus.upd_idx   = '0;
    host_bus.upd_key   = '0;
    host_bus.upd_mask  = '0;
    host_bus.upd_en    = 1'b0;
    tc_srch_done = 1'b0;
    tc_hit       = 1'b0;
    tc_idx       = '0;
    stat_clr     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    total++; if (host_bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%0b want=0", host_bus.res_valid); end
    total++; if (host_bus.upd_ready !== 1'b0) begin bad++; $display("FAIL reset_upd_ready got=%0b want=0", host_bus.upd_ready); end
    total++; if (tc_srch_start !== 1'b0) begin bad++; $display("FAIL reset_srch_start got=%0b want=0", tc_srch_start); end
    total++; if (tc_wr !== 1'b0) begin bad++; $display("FAIL reset_tc_wr got=%0b want=0", tc_wr); end
    total++; if (stat_lookups !== 32'd0) begin bad++; $display("FAIL reset_lookups got=%0d want=0", stat_lookups); end
    total++; if (stat_hits !== 32'd0) begin bad++; $display("FAIL reset_hits got=%0d want=0", stat_hits); end
    total++; if (stat_timeouts !== 16'd0) begin bad++; $display("FAIL reset_timeouts got=%0d want=0", stat_timeouts); end
    resetn = 1'b1;
    tick();
    total++; if (host_bus.pkt_ready !== 1'b0) begin bad++; $display("FAIL reset_pkt_ready got=%0b want=0", host_bus.pkt_ready); end
  endtask

  task automatic test_lookup();
    logic [KEY_W-1:0] k;
    k = {16{8'hA5}};
    host_bus.pkt_valid = 1'b1;
    host_bus.pkt_key   = k;
    host_bus.pkt_tag   = 8'h3C;
    #1;
    total++; if (host_bus.pkt_ready !== 1'b1) begin bad++; $display("FAIL lookup_pkt_ready got=%0b want=1", host_bus.pkt_ready); end
    tick();
    host_bus.pkt_valid = 1'b0;
    total++; if (tc_srch_start !== 1'b1) begin bad++; $display("FAIL lookup_start got=%0b want=1", tc_srch_start); end
    total++; if (tc_srch_key !== k) begin bad++; $display("FAIL lookup_key got=%0h want=%0h", tc_srch_key, k); end
    tick();
    total++; if (tc_srch_start !== 1'b0) begin bad++; $display("FAIL lookup_start_once got=%0b want=0", tc_srch_start); end
    tick();
    total++; if (host_bus.res_valid !== 1'b0) begin bad++; $display("FAIL lookup_early_valid got=%0b want=0", host_bus.res_valid); end
    tick();
    tc_srch_done = 1'b1; tc_hit = 1'b1; tc_idx = 4'd5;
    tick();
    tc_srch_done = 1'b0; tc_hit = 1'b0; tc_idx = '0;
    total++; if (host_bus.res_valid !== 1'b1) begin bad++; $display("FAIL lookup_res_valid got=%0b want=1", host_bus.res_valid); end
    total++; if (host_bus.res_hit !== 1'b1) begin bad++; $display("FAIL lookup_res_hit got=%0b want=1", host_bus.res_hit); end
    total++; if (host_bus.res_idx !== 4'd5) begin bad++; $display("FAIL lookup_res_idx got=%0d want=5", host_bus.res_idx); end
    total++; if (host_bus.res_tag !== 8'h3C) begin bad++; $display("FAIL lookup_res_tag got=%0h want=3c", host_bus.res_tag); end
    total++; if (host_bus.res_err !== 1'b0) begin bad++; $display("FAIL lookup_res_err got=%0b want=0", host_bus.res_err); end
    total++; if (stat_lookups !== 32'd1) begin bad++; $display("FAIL lookup_stat_lookups got=%0d want=1", stat_lookups); end
    total++; if (stat_hits !== 32'd1) begin bad++; $display("FAIL lookup_stat_hits got=%0d want=1", stat_hits); end
    host_bus.res_ready = 1'b1;
    tick();
    host_bus.res_ready = 1'b0;
    total++; if (host_bus.res_valid !== 1'b0) begin bad++; $display("FAIL lookup_res_drop got=%0b want=0", host_bus.res_valid); end
  endtask

  task automatic test_backpressure();
    host_bus.pkt_valid = 1'b1;
    host_bus.pkt_key   = {4{32'h1234_5678}};
    host_bus.pkt_tag   = 8'h11;
    tick();
    host_bus.pkt_valid = 1'b0;
    tick();
    tc_srch_done = 1'b1; tc_hit = 1'b1; tc_idx = 4'd7;
    tick();
    host_bus.pkt_valid = 1'b1;
    host_bus.upd_valid = 1'b1;
    host_bus.upd_idx   = 4'd2;
    for (int i = 0; i < 10; i++) begin
      // engine strobes while the result is parked must not disturb it
      tc_srch_done = i[0]; tc_hit = ~i[0]; tc_idx = 4'd9;
      #1;
      total++; if (host_bus.res_valid !== 1'b1) begin bad++; $display("FAIL bp_res_valid cyc=%0d got=%0b want=1", i, host_bus.res_valid); end
      total++; if (host_bus.res_hit !== 1'b1) begin bad++; $display("FAIL bp_res_hit cyc=%0d got=%0b want=1", i, host_bus.res_hit); end
      total++; if (host_bus.res_idx !== 4'd7) begin bad++; $display("FAIL bp_res_idx cyc=%0d got=%0d want=7", i, host_bus.res_idx); end
      total++; if (host_bus.res_tag !== 8'h11) begin bad++; $display("FAIL bp_res_tag cyc=%0d got=%0h want=11", i, host_bus.res_tag); end
      total++; if (host_bus.pkt_ready !== 1'b0) begin bad++; $display("FAIL bp_pkt_ready cyc=%0d got=%0b want=0", i, host_bus.pkt_ready); end
      total++; if (host_bus.upd_ready !== 1'b0) begin bad++; $display("FAIL bp_upd_ready cyc=%0d got=%0b want=0", i, host_bus.upd_ready); end
      total++; if (tc_srch_start !== 1'b0) begin bad++; $display("FAIL bp_srch_start cyc=%0d got=%0b want=0", i, tc_srch_start); end
      total++; if (tc_wr !== 1'b0) begin bad++; $display("FAIL bp_tc_wr cyc=%0d got=%0b want=0", i, tc_wr); end
      tick();
    end
    tc_srch_done = 1'b0; tc_hit = 1'b0; tc_idx = '0;
    host_bus.upd_valid = 1'b0;
    host_bus.res_ready = 1'b1;
    tick();
    host_bus.res_ready = 1'b0;
    total++; if (host_bus.res_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%0b want=0", host_bus.res_valid); end
    total++; if (host_bus.pkt_ready !== 1'b1) begin bad++; $display("FAIL bp_release_idle got=%0b want=1", host_bus.pkt_ready); end
    host_bus.pkt_valid = 1'b0;
    #1;
    total++; if (stat_lookups !== 32'd2) begin bad++; $display("FAIL bp_stat_lookups got=%0d want=2", stat_lookups); end
    total++; if (stat_hits !== 32'd2) begin bad++; $display("FAIL bp_stat_hits got=%0d want=2", stat_hits); end
  endtask

  task automatic test_timeout();
    int n;
    tc_hit = 1'b1; tc_idx = 4'd9;
    host_bus.pkt_valid = 1'b1;
    host_bus.pkt_key   = {8{16'hBEEF}};
    host_bus.pkt_tag   = 8'h55;
    tick();
    host_bus.pkt_valid = 1'b0;
    n = 0;
    while (host_bus.res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++; if (n !== 16) begin bad++; $display("FAIL timeout_latency got=%0d want=16", n); end
    total++; if (host_bus.res_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%0b want=1", host_bus.res_err); end
    total++; if (host_bus.res_hit !== 1'b0) begin bad++; $display("FAIL timeout_hit got=%0b want=0", host_bus.res_hit); end
    total++; if (host_bus.res_idx !== 4'd0) begin bad++; $display("FAIL timeout_idx got=%0d want=0", host_bus.res_idx); end
    total++; if (host_bus.res_tag !== 8'h55) begin bad++; $display("FAIL timeout_tag got=%0h want=55", host_bus.res_tag); end
    total++; if (stat_timeouts !== 16'd1) begin bad++; $display("FAIL timeout_stat_timeouts got=%0d want=1", stat_timeouts); end
    total++; if (stat_hits !== 32'd2) begin bad++; $display("FAIL timeout_stat_hits got=%0d want=2", stat_hits); end
    total++; if (stat_lookups !== 32'd3) begin bad++; $display("FAIL timeout_stat_lookups got=%0d want=3", stat_lookups); end
    tc_hit = 1'b0; tc_idx = '0;
    host_bus.res_ready = 1'b1;
    tick();
    host_bus.res_ready = 1'b0;
  endtask

  task automatic test_update();
    logic [KEY_W-1:0] k;
    logic [KEY_W-1:0] m;
    k = {4{32'hCAFE_F00D}};
    m = {2{64'hFFFF_0000_FFFF_0000}};
    host_bus.upd_valid = 1'b1;
    host_bus.upd_idx   = 4'd13;
    host_bus.upd_key   = ~k;
    host_bus.upd_mask  = ~m;
    host_bus.upd_en    = 1'b0;
    #1;
    total++; if (host_bus.upd_ready !== 1'b0) begin bad++; $display("FAIL upd_ready_idle got=%0b want=0", host_bus.upd_ready); end
    tick();
    total++; if (host_bus.upd_ready !== 1'b1) begin bad++; $display("FAIL upd_oor_ready got=%0b want=1", host_bus.upd_ready); end
    total++; if (tc_wr !== 1'b0) begin bad++; $display("FAIL upd_oor_tc_wr got=%0b want=0", tc_wr); end
    host_bus.upd_valid = 1'b0;
    tick();
    total++; if (host_bus.upd_ready !== 1'b0) begin bad++; $display("FAIL upd_oor_pulse got=%0b want=0", host_bus.upd_ready); end
    total++; if (tc_wr !== 1'b0) begin bad++; $display("FAIL upd_oor_tc_wr_after got=%0b want=0", tc_wr); end
    host_bus.upd_valid = 1'b1;
    host_bus.upd_idx   = 4'd3;
    host_bus.upd_key   = k;
    host_bus.upd_mask  = m;
    host_bus.upd_en    = 1'b1;
    tick();
    total++; if (host_bus.upd_ready !== 1'b1) begin bad++; $display("FAIL upd_ready got=%0b want=1", host_bus.upd_ready); end
    total++; if (tc_wr !== 1'b1) begin bad++; $display("FAIL upd_tc_wr got=%0b want=1", tc_wr); end
    total++; if (tc_wr_idx !== 4'd3) begin bad++; $display("FAIL upd_idx got=%0d want=3", tc_wr_idx); end
    total++; if (tc_wr_key !== k) begin bad++; $display("FAIL upd_key got=%0h want=%0h", tc_wr_key, k); end
    total++; if (tc_wr_mask !== m) begin bad++; $display("FAIL upd_mask got=%0h want=%0h", tc_wr_mask, m); end
    total++; if (tc_wr_en !== 1'b1) begin bad++; $display("FAIL upd_en got=%0b want=1", tc_wr_en); end
    host_bus.upd_valid = 1'b0;
    tick();
    total++; if (tc_wr !== 1'b0) begin bad++; $display("FAIL upd_tc_wr_pulse got=%0b want=0", tc_wr); end
    total++; if (host_bus.upd_ready !== 1'b0) begin bad++; $display("FAIL upd_ready_pulse got=%0b want=0", host_bus.upd_ready); end
  endtask

  task automatic test_stat_clr();
    host_bus.pkt_valid = 1'b1;
    host_bus.pkt_key   = {16{8'h3C}};
    host_bus.pkt_tag   = 8'h21;
    tick();
    host_bus.pkt_valid = 1'b0;
    tick();
    tc_srch_done = 1'b1; tc_hit = 1'b1; tc_idx = 4'd4;
    stat_clr = 1'b1;
    tick();
    tc_srch_done = 1'b0; tc_hit = 1'b0; tc_idx = '0;
    stat_clr = 1'b0;
    total++; if (host_bus.res_valid !== 1'b1) begin bad++; $display("FAIL clr_res_valid got=%0b want=1", host_bus.res_valid); end
    total++; if (host_bus.res_idx !== 4'd4) begin bad++; $display("FAIL clr_res_idx got=%0d want=4", host_bus.res_idx); end
    total++; if (stat_lookups !== 32'd0) begin bad++; $display("FAIL clr_lookups got=%0d want=0", stat_lookups); end
    total++; if (stat_hits !== 32'd0) begin bad++; $display("FAIL clr_hits got=%0d want=0", stat_hits); end
    total++; if (stat_timeouts !== 16'd0) begin bad++; $display("FAIL clr_timeouts got=%0d want=0", stat_timeouts); end
    host_bus.res_ready = 1'b1;
    tick();
    host_bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    host_bus.pkt_valid = 1'b1;
    host_bus.pkt_key   = {16{8'h77}};
    host_bus.pkt_tag   = 8'h77;
    tick();
    host_bus.pkt_valid = 1'b0;
    tick();
    resetn = 1'b0;
    tc_srch_done = 1'b1; tc_hit = 1'b1; tc_idx = 4'd6;
    tick();
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (host_bus.res_valid !== 1'b0 || tc_wr !== 1'b0 || host_bus.upd_ready !== 1'b0 || tc_srch_start !== 1'b0) seen++;
      if (i == 2) begin tc_srch_done = 1'b0; tc_hit = 1'b0; tc_idx = '0; end
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_activity got=%0d want=0", seen); end
    total++; if (stat_lookups !== 32'd0) begin bad++; $display("FAIL rstmid_lookups got=%0d want=0", stat_lookups); end
    host_bus.pkt_valid = 1'b1;
    #1;
    total++; if (host_bus.pkt_ready !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%0b want=1", host_bus.pkt_ready); end
    host_bus.pkt_valid = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    logic ev [16];
    logic exp_ev [4];
    logic prev_start;
    int n_ev;
    int n_acc;
    int n_start;
    exp_ev = '{1'b1, 1'b0, 1'b1, 1'b0};
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    host_bus.pkt_valid = 1'b1;
    host_bus.pkt_key   = {8{16'h0F0F}};
    host_bus.pkt_tag   = 8'h99;
    host_bus.upd_valid = 1'b1;
    host_bus.upd_idx   = 4'd4;
    host_bus.upd_key   = {16{8'h42}};
    host_bus.upd_mask  = '1;
    host_bus.upd_en    = 1'b1;
    host_bus.res_ready = 1'b1;
    resetn = 1'b1;
    n_ev = 0; n_acc = 0; n_start = 0; prev_start = 1'b0;
    for (int c = 0; c < 34; c++) begin
      #1;
      // 1 = update commit, 0 = packet accept
      if (host_bus.upd_ready === 1'b1 && n_ev < 16) begin ev[n_ev] = 1'b1; n_ev++; end
      if (host_bus.pkt_ready === 1'b1) begin
        n_acc++;
        if (n_ev < 16) begin ev[n_ev] = 1'b0; n_ev++; end
      end
      if (tc_srch_start === 1'b1) n_start++;
      prev_start = tc_srch_start;
      if (c == 23) begin host_bus.pkt_valid = 1'b0; host_bus.upd_valid = 1'b0; end
      tick();
      tc_srch_done = prev_start;
    end
    tc_srch_done = 1'b0;
    host_bus.res_ready = 1'b0;
    total++; if (n_ev < 4) begin bad++; $display("FAIL b2b_event_count got=%0d want>=4", n_ev); end
    for (int i = 0; i < 4; i++) begin
      if (i < n_ev) begin
        total++; if (ev[i] !== exp_ev[i]) begin bad++; $display("FAIL b2b_grant_order pos=%0d got=%0b want=%0b (1=upd)", i, ev[i], exp_ev[i]); end
      end
    end
    total++; if (n_acc !== 4) begin bad++; $display("FAIL b2b_pkt_accepts got=%0d want=4", n_acc); end
    total++; if (n_start !== n_acc) begin bad++; $display("FAIL b2b_starts got=%0d want=%0d", n_start, n_acc); end
    total++; if (stat_lookups !== 32'd4) begin bad++; $display("FAIL b2b_lookups got=%0d want=4", stat_lookups); end
    total++; if (stat_hits !== 32'd0) begin bad++; $display("FAIL b2b_hits got=%0d want=0", stat_hits); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_lookup();
    test_backpressure();
    test_timeout();
    test_update();
    test_stat_clr();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
